mem_write_buffer: RTL and testbench
===================================

// Module: mem_write_buffer
// PURPOSE
//  Posted-write buffer between the data cache's memory-side port and the multi-cycle RAM.
//  Write-back traffic from the cache is acknowledged after one cycle and queued.
//  The queue drains to RAM in the background.
//  Reads are forwarded from the buffer on a hit; on a miss they go to RAM.
//  This hides RAM write latency from the cache and therefore from the pipeline stall.
// PARAMETERS
//  DEPTH   4   number of buffered write entries (power of 2, >=2)
//  ADDR_W  32  address width
//  DATA_W  32  data width
// PORTS
//  clk             in   1       clock; all state updates on rising edge
//  rst             in   1       asynchronous, active-high reset
//  cache_req_addr  in   ADDR_W  request address from cache
//  cache_req_data  in   DATA_W  write data from cache
//  cache_req_wen   in   1       1=write, 0=read
//  cache_req_valid in   1       request valid; held stable until cache_res_valid
//  cache_res_data  out  DATA_W  read data to cache; holds last value between responses
//  cache_res_valid out  1       one-cycle done pulse for the current request
//  ram_req_addr    out  ADDR_W  RAM address (registered)
//  ram_req_data    out  DATA_W  RAM write data (registered)
//  ram_req_wen     out  1       RAM write enable (registered)
//  ram_req_valid   out  1       RAM enable; held high until ram_res_valid
//  ram_res_data    in   DATA_W  RAM read data, valid with ram_res_valid
//  ram_res_valid   in   1       RAM access complete (one-cycle pulse)
//  buf_count       out  $clog2(DEPTH+1)  occupied entries (status/debug)
// BEHAVIOUR
//  Reset: state IDLE; FIFO empty (head=tail=count=0).
//   All outputs are 0. Buffered writes are discarded.
//   ram_req_valid drops immediately, even mid-access.
//  FIFO: circular; head/tail wrap modulo DEPTH. Address match compares the full ADDR_W.
//   At most one entry exists per address (coalescing).
//  States: IDLE, RESP, DRAIN, READ.
//  IDLE, first matching rule wins:
//   1 read, addr hits entry -> cache_res_data<=entry data; ->RESP. No RAM access.
//   2 write, addr hits entry -> overwrite entry data, count unchanged; ->RESP.
//   3 write, miss, count<DEPTH -> push at tail, count+1; ->RESP.
//   4 read, miss -> ram_req_*<={addr,x,0,1}; ->READ. Read misses bypass queued writes; no hazard since addr is not buffered.
//   5 count>0 -> ram_req_*<={head.addr,head.data,1,1}; ->DRAIN. This covers a full-buffer write waiting.
//   6 else stay in IDLE.
//  DRAIN: hold ram_req_*. On ram_res_valid: pop head, count-1, ram_req_valid<=0; ->IDLE.
//   Cache requests are not serviced in DRAIN. An entry in flight is never coalesced into.
//  READ: hold ram_req_*. On ram_res_valid: cache_res_data<=ram_res_data, ram_req_valid<=0; ->RESP.
//  RESP: cache_res_valid=1 for exactly this cycle; ->IDLE.
//   cache_req_valid is ignored in RESP, so the same request is never accepted twice.
//  Latency: hit or write accept = request sampled at edge N, cache_res_valid high in cycle N+1.
//   Read miss: cache_res_valid one cycle after ram_res_valid.
//  RAM order: writes reach RAM in acceptance order. A coalesced write keeps its original slot.
//  ram_res_valid outside DRAIN/READ is ignored.
//  Full + write miss: no acknowledge until one entry drains; then accepted via rule 3.
//  Simultaneous pop and push cannot occur (single-state FSM).
// TESTING
//  T1 reset asserted mid-DRAIN -> ram_req_valid=0 same cycle; buf_count=0; cache_res_valid=0.
//  T2 write 0x10=0xAAAA -> cache_res_valid 1 cycle later, buf_count=1.
//   Next cycle ram write {0x10,0xAAAA} issued; count=0 after ram_res_valid.
//  T3 write 0x20=0x1234, then read 0x20 in the first IDLE cycle -> res_data=0x1234 after 1 cycle.
//   No RAM read issued (ram_req_wen never 0).
//  T4 writes 0x30=1 then 0x30=2 back-to-back -> buf_count stays 1.
//   Exactly one RAM write {0x30,2}.
//  T5 DEPTH=4, RAM latency 5; writes 0x0,0x4,0x8,0xC,0x10 -> first four acked at 1 cycle.
//   Fifth acked only after first drain. RAM sees addresses in order 0x0..0x10.
//  T6 empty buffer; read 0x40; RAM returns 0xBEEF after 3 cycles -> cache_res_data=0xBEEF.
//   cache_res_valid one cycle after ram_res_valid; buf_count stays 0.

Source files
------------

// File: rtl/mem_write_buffer.sv
// mem_write_buffer: posted-write FIFO with read forwarding and write coalescing between cache and RAM
module mem_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          cache_req_addr,
  input  logic [DATA_W-1:0]          cache_req_data,
  input  logic                       cache_req_wen,
  input  logic                       cache_req_valid,
  output logic [DATA_W-1:0]          cache_res_data,
  output logic                       cache_res_valid,
  output logic [ADDR_W-1:0]          ram_req_addr,
  output logic [DATA_W-1:0]          ram_req_data,
  output logic                       ram_req_wen,
  output logic                       ram_req_valid,
  input  logic [DATA_W-1:0]          ram_res_data,
  input  logic                       ram_res_valid,
  output logic [$clog2(DEPTH+1)-1:0] buf_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  typedef enum logic [1:0] {IDLE, RESP, DRAIN, READ} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0] head, tail, hit_idx;
  logic hit, idle_req, rd_hit, wr_hit, push, rd_miss, start_drain, pop, rd_done;
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i] && addr_q[i] == cache_req_addr) begin
        hit = 1'b1;
        hit_idx = PW'(i);
      end
  end
  always_comb begin
    idle_req    = state == IDLE && cache_req_valid;
    rd_hit      = idle_req && !cache_req_wen && hit;
    wr_hit      = idle_req && cache_req_wen && hit;
    push        = idle_req && cache_req_wen && !hit && buf_count != CW'(DEPTH);
    rd_miss     = idle_req && !cache_req_wen && !hit;
    start_drain = state == IDLE && !(rd_hit || wr_hit || push || rd_miss) && buf_count != '0;
    pop         = state == DRAIN && ram_res_valid;
    rd_done     = state == READ && ram_res_valid;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_comb
    state_nx = (rd_hit || wr_hit || push || rd_done) ? RESP :
               rd_miss                               ? READ :
               start_drain                           ? DRAIN :
               (pop || state == RESP)                ? IDLE : state;
  always_comb cache_res_valid = state == RESP;
  // Entry storage needs no reset: the valid bits alone define occupancy
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= cache_req_addr;
      data_q[tail] <= cache_req_data;
    end
    if (wr_hit) data_q[hit_idx] <= cache_req_data;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld            <= '0;
      head           <= '0;
      tail           <= '0;
      buf_count      <= '0;
      cache_res_data <= '0;
      ram_req_addr   <= '0;
      ram_req_data   <= '0;
      ram_req_wen    <= 1'b0;
      ram_req_valid  <= 1'b0;
    end else begin
      if (rd_hit) cache_res_data <= data_q[hit_idx];
      if (push) begin
        vld[tail] <= 1'b1;
        tail      <= tail + PW'(1);
        buf_count <= buf_count + CW'(1);
      end
      if (rd_miss) begin
        ram_req_addr  <= cache_req_addr;
        ram_req_wen   <= 1'b0;
        ram_req_valid <= 1'b1;
      end
      if (start_drain) begin
        ram_req_addr  <= addr_q[head];
        ram_req_data  <= data_q[head];
        ram_req_wen   <= 1'b1;
        ram_req_valid <= 1'b1;
      end
      if (pop) begin
        vld[head]     <= 1'b0;
        head          <= head + PW'(1);
        buf_count     <= buf_count - CW'(1);
        ram_req_valid <= 1'b0;
      end
      if (rd_done) begin
        cache_res_data <= ram_res_data;
        ram_req_valid  <= 1'b0;
      end
    end
endmodule

// File: tb/tb_mem_write_buffer.sv
// tb_mem_write_buffer: randomized cache traffic against a memory-image and pending-write-queue model
module tb_mem_write_buffer;
  localparam int DEPTH = 4;
  localparam int T = 10;
  typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] cache_req_addr = '0, cache_req_data = '0, cache_res_data;
  logic cache_req_wen = 1'b0, cache_req_valid = 1'b0, cache_res_valid;
  logic [31:0] ram_req_addr, ram_req_data, ram_res_data;
  logic ram_req_wen, ram_req_valid, ram_res_valid;
  logic [2:0] buf_count;
  wr_t pend[$];
  logic [31:0] rmem[logic [31:0]];
  logic [31:0] gold[logic [31:0]];
  int checks = 0, errors = 0, ram_reads = 0, lat_fix = 0, cnt = 0, c = 0;
  bit busy = 1'b0;
  time t_res = 0;
  always #(T/2) clk = ~clk;
  mem_write_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .cache_req_addr(cache_req_addr), .cache_req_data(cache_req_data),
    .cache_req_wen(cache_req_wen), .cache_req_valid(cache_req_valid),
    .cache_res_data(cache_res_data), .cache_res_valid(cache_res_valid),
    .ram_req_addr(ram_req_addr), .ram_req_data(ram_req_data),
    .ram_req_wen(ram_req_wen), .ram_req_valid(ram_req_valid),
    .ram_res_data(ram_res_data), .ram_res_valid(ram_res_valid),
    .buf_count(buf_count)
  );
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] init_val(logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction
  function automatic logic [31:0] mem_rd(logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] gold_rd(logic [31:0] a);
    return gold.exists(a) ? gold[a] : init_val(a);
  endfunction
  // RAM model: fixed or random latency, writes must arrive in model-queue order
  initial begin
    ram_res_valid = 1'b0;
    ram_res_data  = '0;
    forever begin
      @(negedge clk);
      ram_res_valid = 1'b0;
      if (rst) busy = 1'b0;
      else if (busy) begin
        cnt--;
        if (cnt == 0) begin
          ram_res_valid = 1'b1;
          busy = 1'b0;
          t_res = $time;
          if (ram_req_wen) begin
            check("ram_wq_nonempty", pend.size() != 0, 1);
            if (pend.size() != 0) begin
              check("ram_waddr", ram_req_addr, pend[0].a);
              check("ram_wdata", ram_req_data, pend[0].d);
              void'(pend.pop_front());
            end
            rmem[ram_req_addr] = ram_req_data;
          end else ram_res_data = mem_rd(ram_req_addr);
        end
      end else if (ram_req_valid) begin
        busy = 1'b1;
        cnt = lat_fix > 0 ? lat_fix : int'($urandom_range(1, 4));
        if (!ram_req_wen) ram_reads++;
      end
    end
  end
  task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d, output int cyc);
    int r0;
    bit inq;
    r0 = ram_reads;
    cache_req_wen = w;
    cache_req_addr = a;
    cache_req_data = d;
    cache_req_valid = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!cache_res_valid && cyc < 300);
    check("ack", cache_res_valid, 1);
    cache_req_valid = 1'b0;
    inq = 1'b0;
    foreach (pend[i])
      if (pend[i].a == a) begin
        inq = 1'b1;
        if (w) pend[i].d = d;
      end
    if (w) begin
      if (!inq) pend.push_back('{a, d});
      gold[a] = d;
      check("count", buf_count, pend.size());
      check("wr_no_ram_read", ram_reads - r0, 0);
    end else begin
      check("rdata", cache_res_data, gold_rd(a));
      check("rd_ram_reads", ram_reads - r0, inq ? 0 : 1);
    end
  endtask
  task automatic wait_drain();
    int n = 0;
    while ((buf_count != 0 || ram_req_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drained", buf_count, 0);
  endtask
  initial begin
    #(T*60000);
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    #(2*T + 2);
    check("rst_ram_valid", ram_req_valid, 0);
    check("rst_res_valid", cache_res_valid, 0);
    check("rst_count", buf_count, 0);
    check("rst_res_data", cache_res_data, 0);
    check("rst_ram_addr", ram_req_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    do_req(1, 32'h10, 32'hAAAA, c);
    check("t2_lat", c, 1);
    wait_drain();
    check("t2_mem", mem_rd(32'h10), 32'hAAAA);
    do_req(1, 32'h20, 32'h1234, c);
    do_req(0, 32'h20, 32'h0, c);
    check("t3_lat", c, 2);
    wait_drain();
    do_req(1, 32'h30, 32'h1, c);
    do_req(1, 32'h30, 32'h2, c);
    wait_drain();
    check("t4_mem", mem_rd(32'h30), 32'h2);
    lat_fix = 5;
    for (int i = 0; i < 5; i++) begin
      do_req(1, 32'(i * 4), $urandom, c);
      if (i < 4) check("t5_lat", c, i == 0 ? 1 : 2);
      else check("t5_full_wait", c > 2, 1);
    end
    wait_drain();
    lat_fix = 3;
    rmem[32'h40] = 32'hBEEF;
    gold[32'h40] = 32'hBEEF;
    do_req(0, 32'h40, 32'h0, c);
    check("t6_gap", $time - t_res, T);
    check("t6_data", cache_res_data, 32'hBEEF);
    check("t6_count", buf_count, 0);
    lat_fix = 20;
    do_req(1, 32'h50, 32'h77, c);
    c = 0;
    while (!ram_req_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("t1_drain_start", ram_req_valid, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t1_ram_valid", ram_req_valid, 0);
    check("t1_count", buf_count, 0);
    check("t1_res_valid", cache_res_valid, 0);
    pend.delete();
    gold = rmem;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    lat_fix = 0;
    repeat (300) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7) * 4), $urandom, c);
    end
    wait_drain();
    check("final_queue", pend.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
